// File: rtl/product_load_sequencer.sv
// Snapshots five product words and writes the non-empty ones in slot order.
// Optional slot-ID check is enabled by defining PRODUCT_ID_CHECK_EN.
module product_load_sequencer #(
  parameter int ID_W    = 3,
  parameter int PRICE_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ID_W+PRICE_W-1:0] p0,
  input  logic [ID_W+PRICE_W-1:0] p1,
  input  logic [ID_W+PRICE_W-1:0] p2,
  input  logic [ID_W+PRICE_W-1:0] p3,
  input  logic [ID_W+PRICE_W-1:0] p4,
  output logic                    wr_valid,
  output logic [2:0]              wr_addr,
  output logic [PRICE_W-1:0]      wr_data,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    done,
  output logic [4:0]              skip_mask,
  output logic                    err
);

  localparam int W = ID_W + PRICE_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t         state, state_nx;
  logic [2:0]     idx, idx_nx;
  logic [W-1:0]   sh [5];
  logic [W-1:0]   cur;
  logic           empty, bad, skip;
  logic           cap;
  logic [4:0]     mask_nx;
  logic           err_nx;

  always_comb begin
    cur = '0;
    unique case (idx)
      3'd0:    cur = sh[0];
      3'd1:    cur = sh[1];
      3'd2:    cur = sh[2];
      3'd3:    cur = sh[3];
      3'd4:    cur = sh[4];
      default: cur = '0;
    endcase
  end

  assign empty = (cur[PRICE_W-1:0] == '0);

`ifdef PRODUCT_ID_CHECK_EN
  assign bad = !empty && (cur[W-1:PRICE_W] != ID_W'(idx));
`else
  logic unused_id;
  assign unused_id = ^cur[W-1:PRICE_W];
  assign bad = 1'b0;
`endif

  assign skip = empty || bad;

  // Outputs decode registered state only.
  assign wr_valid = (state == ISSUE) && !skip;
  assign wr_addr  = (state == ISSUE) ? idx : 3'd0;
  assign wr_data  = wr_valid ? cur[PRICE_W-1:0] : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    mask_nx  = skip_mask;
    err_nx   = err;
    cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cap      = 1'b1;
          mask_nx  = '0;
          err_nx   = 1'b0;
          idx_nx   = 3'd0;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (skip) begin
          mask_nx = skip_mask | (5'b00001 << idx);
          err_nx  = err | bad;
        end
        if (skip || wr_ready) begin
          if (idx == 3'd4) begin
            idx_nx   = 3'd0;
            state_nx = DONE;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      skip_mask <= '0;
      err       <= 1'b0;
      for (int i = 0; i < 5; i++) sh[i] <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      skip_mask <= mask_nx;
      err       <= err_nx;
      if (cap) begin
        sh[0] <= p0;
        sh[1] <= p1;
        sh[2] <= p2;
        sh[3] <= p3;
        sh[4] <= p4;
      end
    end
  end

endmodule
